alu_exec_stage: RTL

Execute-stage wrapper that sits directly upstream of the 16-bit ALU (`alu16`) and captures its output. It accepts decoded operations from the decode stage over a valid/ready handshake, translates a 4-bit function code into the ALU's 3-bit op, applies operand forwarding, and holds operands stable for the ALU. It then registers the ALU result and zero flag into an output buffer consumed by write-back, also over valid/ready.

---
 rtl/alu_exec_stage.sv | 172 +++++++++++++++++
 1 files changed

// File: rtl/alu_exec_stage.sv
// Execute stage in front of alu16: latches and decodes one operation, drives the ALU
// combinationally, and buffers the ALU result for write-back over valid/ready.
module alu_exec_stage (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [3:0]  in_func,
  input  logic [15:0] in_a,
  input  logic [15:0] in_b,
  input  logic        in_fwd_a,
  input  logic        in_fwd_b,
  output logic [15:0] alu_a,
  output logic [15:0] alu_b,
  output logic [2:0]  alu_op,
  input  logic [15:0] alu_r,
  input  logic        alu_zero,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] out_r,
  output logic        out_zero,
  output logic        out_illegal,
  output logic [15:0] op_count
);

  typedef enum logic [3:0] {
    FN_AND = 4'h0,
    FN_OR  = 4'h1,
    FN_ADD = 4'h2,
    FN_SGT = 4'h3,
    FN_SUB = 4'h4,
    FN_SLT = 4'h5,
    FN_NEG = 4'h6,
    FN_INC = 4'h7
  } func_e;

  localparam logic [2:0] OP_AND = 3'd0;
  localparam logic [2:0] OP_OR  = 3'd1;
  localparam logic [2:0] OP_ADD = 3'd2;
  localparam logic [2:0] OP_SGT = 3'd3;
  localparam logic [2:0] OP_SUB = 3'd4;

  function automatic logic is_illegal(input logic [3:0] func);
    is_illegal = (func >= 4'h8);
  endfunction

  logic        s1_valid_r;
  logic [3:0]  s1_func_r;
  logic [15:0] s1_a_r;
  logic [15:0] s1_b_r;
  logic        s1_fwd_a_r;
  logic        s1_fwd_b_r;

  logic        out_valid_r;
  logic [15:0] out_r_r;
  logic        out_zero_r;
  logic        out_illegal_r;
  logic [15:0] last_result_r;
  logic [15:0] op_count_r;

  logic        s1_adv_s;
  logic        accept_s;
  logic        drain_s;
  logic        illegal_s;
  logic [15:0] ea_s;
  logic [15:0] eb_s;
  logic [15:0] result_s;
  logic        zero_s;

  assign s1_adv_s  = s1_valid_r && (!out_valid_r || out_ready);
  assign in_ready  = !s1_valid_r || s1_adv_s;
  assign accept_s  = in_valid && in_ready;
  assign drain_s   = out_valid_r && out_ready;
  assign illegal_s = is_illegal(s1_func_r);

  // last_result_r is always the result of the op just ahead, so forwarding never stalls
  assign ea_s = s1_fwd_a_r ? last_result_r : s1_a_r;
  assign eb_s = s1_fwd_b_r ? last_result_r : s1_b_r;

  assign result_s = illegal_s ? 16'h0000 : alu_r;
  assign zero_s   = illegal_s ? 1'b0 : alu_zero;

  // Function-code decode onto the ALU ports; SLT reuses SGT with swapped operands
  always_comb begin
    alu_op = OP_AND;
    alu_a  = 16'h0000;
    alu_b  = 16'h0000;
    if (s1_valid_r) begin
      case (s1_func_r)
        FN_AND: begin alu_op = OP_AND; alu_a = ea_s;      alu_b = eb_s;      end
        FN_OR:  begin alu_op = OP_OR;  alu_a = ea_s;      alu_b = eb_s;      end
        FN_ADD: begin alu_op = OP_ADD; alu_a = ea_s;      alu_b = eb_s;      end
        FN_SGT: begin alu_op = OP_SGT; alu_a = ea_s;      alu_b = eb_s;      end
        FN_SUB: begin alu_op = OP_SUB; alu_a = ea_s;      alu_b = eb_s;      end
        FN_SLT: begin alu_op = OP_SGT; alu_a = eb_s;      alu_b = ea_s;      end
        FN_NEG: begin alu_op = OP_SUB; alu_a = 16'h0000;  alu_b = eb_s;      end
        FN_INC: begin alu_op = OP_ADD; alu_a = ea_s;      alu_b = 16'h0001;  end
        default: begin
          alu_op = OP_AND;
          alu_a  = 16'h0000;
          alu_b  = 16'h0000;
        end
      endcase
    end else begin
      alu_op = OP_AND;
      alu_a  = 16'h0000;
      alu_b  = 16'h0000;
    end
  end

  // Operand latch
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_r <= 1'b0;
      s1_func_r  <= 4'h0;
      s1_a_r     <= 16'h0000;
      s1_b_r     <= 16'h0000;
      s1_fwd_a_r <= 1'b0;
      s1_fwd_b_r <= 1'b0;
    end else if (accept_s) begin
      s1_valid_r <= 1'b1;
      s1_func_r  <= in_func;
      s1_a_r     <= in_a;
      s1_b_r     <= in_b;
      s1_fwd_a_r <= in_fwd_a;
      s1_fwd_b_r <= in_fwd_b;
    end else if (s1_adv_s) begin
      s1_valid_r <= 1'b0;
    end else begin
      s1_valid_r <= s1_valid_r;
    end
  end

  // Output buffer and forwarding register; a refill in the drain cycle keeps out_valid high
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid_r   <= 1'b0;
      out_r_r       <= 16'h0000;
      out_zero_r    <= 1'b0;
      out_illegal_r <= 1'b0;
      last_result_r <= 16'h0000;
    end else if (s1_adv_s) begin
      out_valid_r   <= 1'b1;
      out_r_r       <= result_s;
      out_zero_r    <= zero_s;
      out_illegal_r <= illegal_s;
      last_result_r <= result_s;
    end else if (drain_s) begin
      out_valid_r   <= 1'b0;
    end else begin
      out_valid_r   <= out_valid_r;
    end
  end

  // Delivered-result counter, wraps naturally at 16 bits
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      op_count_r <= 16'h0000;
    end else if (drain_s) begin
      op_count_r <= op_count_r + 16'h0001;
    end else begin
      op_count_r <= op_count_r;
    end
  end

  assign out_valid   = out_valid_r;
  assign out_r       = out_r_r;
  assign out_zero    = out_zero_r;
  assign out_illegal = out_illegal_r;
  assign op_count    = op_count_r;

endmodule
